// File: rtl/meas_pkg.sv
// Shared types and helpers for the period-measurement sequencer.
package meas_pkg;

  localparam int MEAS_W = 32;

  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    LAUNCH  = 7'b0000010,
    WAIT_HI = 7'b0000100,
    WAIT_LO = 7'b0001000,
    SELECT  = 7'b0010000,
    ACCUM   = 7'b0100000,
    OUTPUT  = 7'b1000000
  } seq_state_t;

  // Shift amount that turns an NAVG-run sum into an average (NAVG is a power of two up to 256).
  function automatic int clog2_navg(input int navg);
    int r;
    r = 0;
    for (int i = 0; i < 9; i++) begin
      if ((1 << i) < navg) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/meas_chan_select.sv
// Picks the finest-resolution channel whose count is neither empty nor saturated;
// falls back to the slowest channel and flags it when none qualifies.
module meas_chan_select
  import meas_pkg::*;
#(
  parameter int                NCH       = 10,
  parameter logic [MEAS_W-1:0] SAT_LIMIT = 32'h7FFF_FFFF
) (
  input  logic [NCH-1:0][MEAS_W-1:0] meas_val,
  output logic [3:0]                 ch,
  output logic [MEAS_W-1:0]          value,
  output logic                       none
);

  // Scan from the slowest channel down so the lowest usable index is the one that sticks.
  always_comb begin
    ch    = 4'(NCH - 1);
    value = meas_val[NCH-1];
    none  = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((meas_val[i] != '0) && (meas_val[i] < SAT_LIMIT)) begin
        ch    = 4'(i);
        value = meas_val[i];
        none  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/meas_sequencer.sv
// Drives the multi-channel period engine, averages NAVG runs and presents the result on valid/ready.
// Define MEAS_TIMEOUT_EN to add a per-wait watchdog that forces a flagged zero result.
module meas_sequencer
  import meas_pkg::*;
#(
  parameter int                NCH       = 10,
  parameter int                NAVG      = 4,
  parameter logic [MEAS_W-1:0] SAT_LIMIT = 32'h7FFF_FFFF,
  parameter int                TIMEOUT   = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       trig,
  output logic                       meas_start,
  input  logic                       meas_busy,
  input  logic [NCH-1:0][MEAS_W-1:0] meas_val,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [MEAS_W-1:0]          res_val,
  output logic [3:0]                 res_ch,
  output logic                       res_ovf,
  output logic                       res_timeout,
  output logic                       idle
);

  localparam int               SH       = clog2_navg(NAVG);
  localparam int               ACC_W    = MEAS_W + SH;
  localparam int               CNT_W    = (SH == 0) ? 1 : SH;
  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(NAVG - 1);

  seq_state_t        r_state;
  seq_state_t        w_stateNext;
  logic [1:0]        r_launchCnt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_accSum;
  logic [CNT_W-1:0]  r_runCnt;
  logic [3:0]        r_selCh;
  logic [MEAS_W-1:0] r_selVal;
  logic              r_selNone;
  logic [3:0]        r_resCh;
  logic [MEAS_W-1:0] r_resVal;
  logic              r_ovf;
  logic              r_timeout;
  logic [3:0]        w_ch;
  logic [MEAS_W-1:0] w_value;
  logic              w_none;
  logic              w_accept;
  logic              w_begin;
  logic              w_timeoutHit;

  meas_chan_select #(
    .NCH       (NCH),
    .SAT_LIMIT (SAT_LIMIT)
  ) u_chan_select (
    .meas_val (meas_val),
    .ch       (w_ch),
    .value    (w_value),
    .none     (w_none)
  );

  assign w_accept = (r_state == OUTPUT) && res_ready;
  assign w_begin  = (r_state == IDLE) && (run || trig);
  assign w_accSum = r_acc + ACC_W'(r_selVal);

`ifdef MEAS_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        w_waiting;

  assign w_waiting    = (r_state == WAIT_HI) || (r_state == WAIT_LO);
  assign w_timeoutHit = w_waiting && (r_wdog == 32'(TIMEOUT - 1));

  // Restarts from zero on every entry into a wait state, so each phase gets the full budget.
  always_ff @(posedge clk) begin
    if (!rst_n || !w_waiting || (w_stateNext != r_state)) r_wdog <= '0;
    else                                                  r_wdog <= r_wdog + 32'd1;
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^32'(TIMEOUT);
  assign w_timeoutHit     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (run || trig) w_stateNext = LAUNCH;
      LAUNCH:  if (r_launchCnt == 2'd2) w_stateNext = WAIT_HI;
      WAIT_HI: begin
        if (w_timeoutHit)   w_stateNext = OUTPUT;
        else if (meas_busy) w_stateNext = WAIT_LO;
      end
      WAIT_LO: begin
        if (w_timeoutHit)    w_stateNext = OUTPUT;
        else if (!meas_busy) w_stateNext = SELECT;
      end
      SELECT:  w_stateNext = ACCUM;
      ACCUM:   w_stateNext = (r_runCnt == LAST_RUN) ? OUTPUT : LAUNCH;
      OUTPUT:  if (res_ready) w_stateNext = run ? LAUNCH : IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    meas_start = 1'b0;
    res_valid  = 1'b0;
    idle       = 1'b0;
    case (r_state)
      IDLE:    idle       = 1'b1;
      LAUNCH:  meas_start = (r_launchCnt != 2'd0);
      OUTPUT:  res_valid  = 1'b1;
      default: ;
    endcase
  end

  // Count 0 holds off until the engine is idle (it may still be finishing a run cut short by reset);
  // counts 1 and 2 are the two start cycles.
  always_ff @(posedge clk) begin
    if (!rst_n || (w_stateNext != LAUNCH))          r_launchCnt <= 2'd0;
    else if ((r_launchCnt != 2'd0) || !meas_busy)   r_launchCnt <= r_launchCnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_selCh   <= '0;
      r_selVal  <= '0;
      r_selNone <= 1'b0;
      r_acc     <= '0;
      r_runCnt  <= '0;
      r_resCh   <= '0;
      r_resVal  <= '0;
      r_ovf     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == SELECT) begin
        r_selCh   <= w_ch;
        r_selVal  <= w_value;
        r_selNone <= w_none;
      end
      if (w_begin || w_accept) begin
        r_acc     <= '0;
        r_runCnt  <= '0;
        r_ovf     <= 1'b0;
        r_timeout <= 1'b0;
      end else if (r_state == ACCUM) begin
        r_acc    <= w_accSum;
        r_runCnt <= r_runCnt + CNT_W'(1);
        r_ovf    <= r_ovf | r_selNone;
        r_resCh  <= r_selCh;
        if (r_runCnt == LAST_RUN) r_resVal <= MEAS_W'(w_accSum >> SH);
      end else if (w_timeoutHit) begin
        r_resVal  <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign res_val     = r_resVal;
  assign res_ch      = r_resCh;
  assign res_ovf     = r_ovf;
  assign res_timeout = r_timeout;

endmodule

// File: tb/tb_meas_sequencer.sv
// Randomized scoreboard bench for meas_sequencer with a behavioural engine and averaging model.
module tb_meas_sequencer;
  import meas_pkg::*;

  localparam int          NCH  = 10;
  localparam int          NAVG = 4;
  localparam logic [31:0] SAT  = 32'h7FFF_FFFF;
  localparam int          TMO  = 100;

  typedef logic [NCH-1:0][31:0] vals_t;
  typedef struct packed {
    logic [31:0] val;
    logic [3:0]  ch;
    logic        ovf;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, run, trig, meas_start, meas_busy;
  logic        res_valid, res_ready, res_ovf, res_timeout, idle;
  vals_t       meas_val;
  logic [31:0] res_val;
  logic [3:0]  res_ch;

  exp_t            expQ[$];
  int              checks = 0;
  int              errors = 0;
  longint unsigned mSum = 0;
  int              mCnt = 0;
  logic            mOvf = 1'b0;
  logic [3:0]      mLastCh = 4'd0;
  int              pat = 0;
  bit              readyRand = 1'b0;
  bit              engineDead = 1'b0;
  bit              discardRun = 1'b0;
  int              startPulses = 0;
  int              accepted = 0;
  logic [31:0]     lastVal;
  logic [3:0]      lastCh;
  logic            lastOvf;

  always #5 clk = ~clk;

  meas_sequencer #(
    .NCH(NCH), .NAVG(NAVG), .SAT_LIMIT(SAT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .trig(trig),
    .meas_start(meas_start), .meas_busy(meas_busy), .meas_val(meas_val),
    .res_valid(res_valid), .res_ready(res_ready), .res_val(res_val),
    .res_ch(res_ch), .res_ovf(res_ovf), .res_timeout(res_timeout), .idle(idle)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vals_t genVals(input int p, input int runIdx);
    vals_t v;
    for (int i = 0; i < NCH; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i] = 32'd0;
        1:       v[i] = SAT + $urandom_range(0, 1000);
        default: v[i] = $urandom_range(1, 100000);
      endcase
    end
    case (p)
      1: begin v[0] = 32'd0; v[1] = 32'd100; end
      2: begin v[0] = 32'd0; v[1] = SAT; v[2] = 32'(10 + runIdx); end
      3: begin
        for (int i = 0; i < NCH; i++)
          v[i] = ($urandom_range(0, 1) != 0) ? 32'd0 : SAT + $urandom_range(0, 1000);
        v[NCH-1] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : SAT + $urandom_range(1, 1000);
      end
      default: ;
    endcase
    return v;
  endfunction

  // Reference: lowest usable channel per run, plain integer average over NAVG runs.
  function automatic void modelRun(input vals_t v);
    int ch;
    ch = -1;
    for (int i = 0; i < NCH; i++)
      if (ch < 0 && v[i] != 0 && v[i] < SAT) ch = i;
    if (ch < 0) begin
      ch   = NCH - 1;
      mOvf = 1'b1;
    end
    mSum    += v[ch];
    mCnt++;
    mLastCh = 4'(ch);
    if (mCnt == NAVG) begin
      expQ.push_back('{32'(mSum / NAVG), 4'(ch), mOvf, 1'b0});
      mSum = 0;
      mCnt = 0;
      mOvf = 1'b0;
    end
  endfunction

  // Behavioural engine: answers each start pulse with a busy window and fresh channel counts.
  initial begin : engine
    int    width;
    vals_t v;
    meas_busy = 1'b0;
    meas_val  = '0;
    forever begin
      @(negedge clk);
      if (meas_start === 1'b1) begin
        width = 1;
        @(negedge clk);
        while (meas_start === 1'b1 && width < 8) begin
          width++;
          @(negedge clk);
        end
        startPulses++;
        checkOutput("start_width", 64'(width), 64'd2);
        if (!engineDead) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          v         = genVals(pat, mCnt);
          meas_busy = 1'b1;
          meas_val  = v;
          repeat ($urandom_range(8, 30)) @(negedge clk);
          meas_busy = 1'b0;
          if (discardRun) discardRun = 1'b0;
          else            modelRun(v);
        end
      end
    end
  end

  initial begin : readyDriver
    forever begin
      @(posedge clk);
      #1;
      if (readyRand) res_ready = ($urandom_range(0, 2) != 0);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
      accepted++;
      lastVal = res_val;
      lastCh  = res_ch;
      lastOvf = res_ovf;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL result_unexpected: got val %0d ch %0d, expected no result", res_val, res_ch);
      end else begin
        e = expQ.pop_front();
        checkOutput("res_val", 64'(res_val), 64'(e.val));
        checkOutput("res_ch", 64'(res_ch), 64'(e.ch));
        checkOutput("res_ovf", 64'(res_ovf), 64'(e.ovf));
        checkOutput("res_timeout", 64'(res_timeout), 64'(e.tmo));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int p);
    pat  = p;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic waitResults(input int target, input int budget);
    int n;
    n = 0;
    while (accepted < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("result_wait", 64'(accepted >= target), 64'd1);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle_wait", 64'(idle), 64'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_meas_start"}, 64'(meas_start), 64'd0);
    checkOutput({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    checkOutput({tag, "_res_val"}, 64'(res_val), 64'd0);
    checkOutput({tag, "_res_ch"}, 64'(res_ch), 64'd0);
    checkOutput({tag, "_res_ovf"}, 64'(res_ovf), 64'd0);
    checkOutput({tag, "_res_timeout"}, 64'(res_timeout), 64'd0);
    checkOutput({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin : guard
    #500_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] stopping");
  end

  initial begin : stimulus
    int          s0, target, bad, n;
    logic [31:0] cv;
    logic [3:0]  cc;
    logic        co;

    rst_n = 1'b0; run = 1'b0; trig = 1'b0; res_ready = 1'b1;
    repeat (3) tick();
    checkResetState("reset");
    rst_n = 1'b1;
    tick();

    // Test 1: finest usable channel is ch1 with a constant count.
    s0 = startPulses; target = accepted + 1;
    applyStimulus(1);
    waitResults(target, 3000);
    checkOutput("t1_start_pulses", 64'(startPulses - s0), 64'd4);
    checkOutput("t1_val", 64'(lastVal), 64'd100);
    checkOutput("t1_ch", 64'(lastCh), 64'd1);
    checkOutput("t1_ovf", 64'(lastOvf), 64'd0);
    waitIdle(20);

    // Test 2: ch2 ramps 10..13, average truncates to 11.
    target = accepted + 1;
    applyStimulus(2);
    waitResults(target, 3000);
    checkOutput("t2_val", 64'(lastVal), 64'd11);
    checkOutput("t2_ch", 64'(lastCh), 64'd2);
    waitIdle(20);

    // Test 3: nothing usable -> slowest channel, sticky overflow.
    target = accepted + 1;
    applyStimulus(3);
    waitResults(target, 3000);
    checkOutput("t3_ch", 64'(lastCh), 64'd9);
    checkOutput("t3_ovf", 64'(lastOvf), 64'd1);
    waitIdle(20);

    // Random one-shot results with a randomly stalling consumer.
    readyRand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      target = accepted + 1;
      applyStimulus($urandom_range(0, 3));
      waitResults(target, 4000);
      waitIdle(40);
    end

    // Continuous mode, then drop run mid-stream.
    pat = 0; run = 1'b1; target = accepted + 3;
    waitResults(target, 10000);
    run = 1'b0;
    waitIdle(4000);
    checkOutput("cont_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("cont_model_runs", 64'(mCnt), 64'd0);
    readyRand = 1'b0;

    // Test 4: stalled consumer holds the result and blocks new launches.
    res_ready = 1'b0; run = 1'b1; pat = 0; n = 0;
    while (res_valid !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    checkOutput("t4_valid_seen", 64'(res_valid), 64'd1);
    cv = res_val; cc = res_ch; co = res_ovf; bad = 0;
    repeat (50) begin
      tick();
      if (res_valid !== 1'b1 || res_val !== cv || res_ch !== cc || res_ovf !== co || meas_start !== 1'b0) bad++;
    end
    checkOutput("t4_hold_violations", 64'(bad), 64'd0);
    res_ready = 1'b1;
    tick();
    checkOutput("t4_valid_dropped", 64'(res_valid), 64'd0);
    checkOutput("t4_not_idle", 64'(idle), 64'd0);
    tick();
    checkOutput("t4_relaunch", 64'(meas_start), 64'd1);
    run = 1'b0;
    waitIdle(4000);
    checkOutput("t4_queue_empty", 64'(expQ.size()), 64'd0);

    // Test 5: reset during WAIT_LO, then re-trigger while the engine is still busy.
    applyStimulus(0);
    n = 0;
    while (meas_busy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    repeat (2) tick();
    discardRun = 1'b1;
    rst_n = 1'b0;
    tick();
    checkResetState("t5");
    mSum = 0; mCnt = 0; mOvf = 1'b0; mLastCh = 4'd0;
    rst_n = 1'b1; trig = 1'b1; target = accepted + 1;
    tick();
    trig = 1'b0; bad = 0; n = 0;
    while (meas_busy === 1'b1 && n < 200) begin
      if (meas_start !== 1'b0) bad++;
      tick();
      n++;
    end
    checkOutput("t5_start_held_off", 64'(bad), 64'd0);
    waitResults(target, 3000);
    waitIdle(20);

`ifdef MEAS_TIMEOUT_EN
    // Test 6: engine never responds; watchdog forces a flagged zero result.
    engineDead = 1'b1;
    expQ.push_back('{32'd0, mLastCh, 1'b0, 1'b1});
    target = accepted + 1;
    applyStimulus(0);
    waitResults(target, 1000);
    waitIdle(20);
    engineDead = 1'b0;
`endif

    checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
